// File: rtl/fft_frame_sequencer.sv
// Frame sequencer in front of a stall-only SDF FFT pipeline: feeds samples,
// injects zero flush frames, and forwards only results belonging to real frames.
module fft_frame_sequencer #(
    parameter int WIDTH           = 16,
    parameter int N               = 256,
    parameter int MAX_OUTSTANDING = 4,
    parameter int IDLE_TIMEOUT    = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_real,
    input  logic [WIDTH-1:0] s_imag,
    input  logic             s_last,
    input  logic             flush_req,
    output logic             fft_input_en,
    output logic [WIDTH-1:0] fft_input_real,
    output logic [WIDTH-1:0] fft_input_imag,
    input  logic             fft_output_en,
    input  logic [WIDTH-1:0] fft_output_real,
    input  logic [WIDTH-1:0] fft_output_imag,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_real,
    output logic [WIDTH-1:0] m_imag,
    output logic             m_first,
    output logic             m_last,
    output logic [7:0]       m_frame_idx,
    output logic             busy,
    output logic             err_misalign
);
    localparam int CW = $clog2(N);
    localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int IW = $clog2(IDLE_TIMEOUT + 2);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {STREAM, FLUSH} state_t;

    state_t               state_q, state_d;
    logic                 run_q, run_d;
    logic [CW-1:0]        in_cnt_q, in_cnt_d;
    logic [CW-1:0]        fl_cnt_q, fl_cnt_d;
    logic [CW-1:0]        out_cnt_q, out_cnt_d;
    logic [IW-1:0]        idle_cnt_q, idle_cnt_d;
    logic [7:0]           frame_idx_q, frame_idx_d;
    logic                 pending_q, pending_d;
    logic [MAX_OUTSTANDING-1:0] tags_q, tags_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]        count_q, count_d;
    logic [OW-1:0]        real_cnt_q, real_cnt_d;
    logic                 err_q, err_d;
    logic                 in_en_q, in_en_d;
    logic [WIDTH-1:0]     in_re_q, in_re_d;
    logic [WIDTH-1:0]     in_im_q, in_im_d;
    logic                 mv_q, mv_d;
    logic [WIDTH-1:0]     m_re_q, m_re_d;
    logic [WIDTH-1:0]     m_im_q, m_im_d;
    logic                 mf_q, mf_d;
    logic                 ml_q, ml_d;
    logic [7:0]           midx_q, midx_d;

    logic full, empty, head, any_real, boundary;
    logic accept, pop, push, push_real, flush_go, flush_again, idle;

    always_comb begin
        full      = count_q == OW'(MAX_OUTSTANDING);
        empty     = count_q == '0;
        head      = tags_q[rd_ptr_q];
        any_real  = real_cnt_q != '0;
        boundary  = in_cnt_q == '0;
        s_ready   = run_q && state_q == STREAM
                    && !(boundary && (full || pending_q));
        accept    = s_valid && s_ready;
        pop       = fft_output_en && !empty && out_cnt_q == LAST;
        flush_go  = state_q == STREAM && boundary && pending_q
                    && !full && !accept;
        flush_again = state_q == FLUSH && fl_cnt_q == LAST
                      && any_real && !full;
        push_real = accept && boundary;
        push      = push_real || flush_go || flush_again;
        idle      = state_q == STREAM && boundary && !accept
                    && any_real && !pending_q;
        busy      = state_q == FLUSH || any_real || !boundary;

        state_d     = state_q;
        run_d       = 1'b1;
        in_cnt_d    = in_cnt_q;
        fl_cnt_d    = fl_cnt_q;
        out_cnt_d   = out_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        frame_idx_d = frame_idx_q;
        pending_d   = pending_q;
        tags_d      = tags_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        real_cnt_d  = real_cnt_q;
        err_d       = err_q;
        in_en_d     = 1'b0;
        in_re_d     = in_re_q;
        in_im_d     = in_im_q;
        mv_d        = 1'b0;
        m_re_d      = m_re_q;
        m_im_d      = m_im_q;
        mf_d        = 1'b0;
        ml_d        = 1'b0;
        midx_d      = midx_q;

        if (accept) begin
            in_en_d  = 1'b1;
            in_re_d  = s_real;
            in_im_d  = s_imag;
            in_cnt_d = in_cnt_q + CW'(1);
            if (s_last && in_cnt_q != LAST) err_d = 1'b1;
        end else if (state_q == FLUSH) begin
            in_en_d = 1'b1;
            in_re_d = '0;
            in_im_d = '0;
        end

        if (accept || !any_real) begin
            idle_cnt_d = '0;
        end else if (idle) begin
            idle_cnt_d = idle_cnt_q + IW'(1);
            if (IDLE_TIMEOUT != 0 && idle_cnt_d == IW'(IDLE_TIMEOUT)) begin
                pending_d  = 1'b1;
                idle_cnt_d = '0;
            end
        end
        if (flush_req && any_real && state_q == STREAM) pending_d = 1'b1;

        unique case (state_q)
            STREAM: begin
                if (flush_go) begin
                    state_d   = FLUSH;
                    pending_d = 1'b0;
                    fl_cnt_d  = '0;
                end
            end
            FLUSH: begin
                fl_cnt_d = fl_cnt_q + CW'(1);
                if (fl_cnt_q == LAST && !flush_again) state_d = STREAM;
            end
            default: state_d = STREAM;
        endcase

        if (push) begin
            tags_d[wr_ptr_q] = push_real;
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            if (head) frame_idx_d = frame_idx_q + 8'd1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + OW'(1);
            2'b01:   count_d = count_q - OW'(1);
            default: count_d = count_q;
        endcase
        case ({push_real, pop && head})
            2'b10:   real_cnt_d = real_cnt_q + OW'(1);
            2'b01:   real_cnt_d = real_cnt_q - OW'(1);
            default: real_cnt_d = real_cnt_q;
        endcase

        // Pipeline output is counted even for dummy frames to keep framing.
        if (fft_output_en) out_cnt_d = out_cnt_q + CW'(1);
        if (fft_output_en && !empty && head) begin
            mv_d   = 1'b1;
            m_re_d = fft_output_real;
            m_im_d = fft_output_imag;
            mf_d   = out_cnt_q == '0;
            ml_d   = out_cnt_q == LAST;
            midx_d = frame_idx_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= STREAM;
            run_q       <= 1'b0;
            in_cnt_q    <= '0;
            fl_cnt_q    <= '0;
            out_cnt_q   <= '0;
            idle_cnt_q  <= '0;
            frame_idx_q <= '0;
            pending_q   <= 1'b0;
            tags_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            real_cnt_q  <= '0;
            err_q       <= 1'b0;
            in_en_q     <= 1'b0;
            in_re_q     <= '0;
            in_im_q     <= '0;
            mv_q        <= 1'b0;
            m_re_q      <= '0;
            m_im_q      <= '0;
            mf_q        <= 1'b0;
            ml_q        <= 1'b0;
            midx_q      <= '0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            in_cnt_q    <= in_cnt_d;
            fl_cnt_q    <= fl_cnt_d;
            out_cnt_q   <= out_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            frame_idx_q <= frame_idx_d;
            pending_q   <= pending_d;
            tags_q      <= tags_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            real_cnt_q  <= real_cnt_d;
            err_q       <= err_d;
            in_en_q     <= in_en_d;
            in_re_q     <= in_re_d;
            in_im_q     <= in_im_d;
            mv_q        <= mv_d;
            m_re_q      <= m_re_d;
            m_im_q      <= m_im_d;
            mf_q        <= mf_d;
            ml_q        <= ml_d;
            midx_q      <= midx_d;
        end
    end

    assign fft_input_en   = in_en_q;
    assign fft_input_real = in_re_q;
    assign fft_input_imag = in_im_q;
    assign m_valid        = mv_q;
    assign m_real         = m_re_q;
    assign m_imag         = m_im_q;
    assign m_first        = mf_q;
    assign m_last         = ml_q;
    assign m_frame_idx    = midx_q;
    assign err_misalign   = err_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Bench for fft_frame_sequencer: stall-only identity pipeline model of depth N,
// randomized frames, scoreboard of expected real-frame results.
module tb_fft_frame_sequencer;
    localparam int W  = 16;
    localparam int N  = 16;
    localparam int MO = 2;
    localparam int IT = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_valid = 1'b0, s_last = 1'b0, flush_req = 1'b0;
    logic [W-1:0] s_real = '0, s_imag = '0;
    logic s_ready, fft_input_en, m_valid, m_first, m_last, busy, err_misalign;
    logic [W-1:0] fft_input_real, fft_input_imag, m_real, m_imag;
    logic [7:0] m_frame_idx;
    logic pe_en = 1'b0;
    logic [W-1:0] pe_re = '0, pe_im = '0;

    fft_frame_sequencer #(
        .WIDTH(W), .N(N), .MAX_OUTSTANDING(MO), .IDLE_TIMEOUT(IT)
    ) dut (
        .clock(clk), .reset(rst_n),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_real(s_real), .s_imag(s_imag), .s_last(s_last),
        .flush_req(flush_req),
        .fft_input_en(fft_input_en),
        .fft_input_real(fft_input_real), .fft_input_imag(fft_input_imag),
        .fft_output_en(pe_en),
        .fft_output_real(pe_re), .fft_output_imag(pe_im),
        .m_valid(m_valid), .m_real(m_real), .m_imag(m_imag),
        .m_first(m_first), .m_last(m_last), .m_frame_idx(m_frame_idx),
        .busy(busy), .err_misalign(err_misalign)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic first;
        logic last;
        logic [7:0] idx;
    } exp_t;

    exp_t sb[$];
    logic [31:0] pq[$];
    int n_cmp = 0, n_bad = 0, delivered = 0;
    int src_cnt = 0;
    bit last_acc = 0, saw_stall = 0;
    logic [W-1:0] last_re = '0, last_im = '0;
    logic [7:0] model_idx = '0;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    // Pipeline stand-in: each enabled input pushes one sample out once N are held.
    always @(posedge clk) begin : pipe
        logic [31:0] w;
        if (!rst_n) begin
            pq.delete();
            pe_en <= 1'b0;
            pe_re <= '0;
            pe_im <= '0;
        end else begin
            pe_en <= 1'b0;
            if (fft_input_en) begin
                pq.push_back({fft_input_real, fft_input_imag});
                if (pq.size() > N) begin
                    w = pq.pop_front();
                    pe_en <= 1'b1;
                    pe_re <= w[31:16];
                    pe_im <= w[15:0];
                end
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (m_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out: got re=%h im=%h idx=%0d expected none",
                         m_real, m_imag, m_frame_idx);
            end else begin
                e = sb.pop_front();
                chk("m_data", {m_real, m_imag}, {e.re, e.im});
                chk("m_marks", 32'({m_first, m_last, m_frame_idx}),
                    32'({e.first, e.last, e.idx}));
                delivered++;
            end
        end
    end

    task automatic lat_check();
        if (last_acc) begin
            chk("in_en", 32'(fft_input_en), 32'd1);
            chk("in_data", {fft_input_real, fft_input_imag}, {last_re, last_im});
        end else if (src_cnt != 0) begin
            chk("in_en_gap", 32'(fft_input_en), 32'd0);
        end
    endtask

    task automatic send_frame(input bit impulse, input bit gaps,
                              input int bad_last, input int stop_at);
        logic [W-1:0] fr_re[N];
        logic [W-1:0] fr_im[N];
        int i = 0;
        int waits = 0;
        bit acc;
        for (int k = 0; k < N; k++) begin
            fr_re[k] = impulse ? ((k == 0) ? 16'h0100 : 16'h0) : W'($urandom);
            fr_im[k] = impulse ? 16'h0 : W'($urandom);
        end
        while (i < stop_at) begin
            @(negedge clk);
            lat_check();
            s_valid = (gaps && i > 0) ? ~s_valid : 1'b1;
            s_real  = fr_re[i];
            s_imag  = fr_im[i];
            s_last  = (i == N - 1) || (i == bad_last);
            #1;
            acc = s_valid && s_ready;
            if (s_valid && !s_ready && src_cnt == 0) saw_stall = 1;
            last_acc = acc;
            last_re  = s_real;
            last_im  = s_imag;
            if (acc) begin
                i++;
                src_cnt = (src_cnt + 1) % N;
                waits = 0;
            end else if (++waits > 400) begin
                n_cmp++;
                n_bad++;
                $display("FAIL accept_timeout: got no accept expected sample %0d", i);
                return;
            end
        end
        if (stop_at == N) begin
            for (int k = 0; k < N; k++)
                sb.push_back('{fr_re[k], fr_im[k], k == 0, k == N - 1, model_idx});
            model_idx++;
        end
    endtask

    task automatic src_idle();
        @(negedge clk);
        lat_check();
        s_valid  = 1'b0;
        s_last   = 1'b0;
        last_acc = 0;
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
    endtask

    task automatic drain(input string nm);
        int c = 0;
        while ((sb.size() != 0 || busy) && c < 1000) begin
            @(negedge clk);
            c++;
        end
        chk({nm, "_left"}, 32'(sb.size()), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic reset_chk(input string nm);
        chk({nm, "_ctl"}, 32'({s_ready, fft_input_en, m_valid, m_first,
                               m_last, busy, err_misalign}), 32'd0);
        chk({nm, "_data"}, {fft_input_real, fft_input_imag}, 32'd0);
        chk({nm, "_mdat"}, {m_real, m_imag}, 32'd0);
        chk({nm, "_idx"}, 32'(m_frame_idx), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        reset_chk("rst0");
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(s_ready), 32'd1);

        delivered = 0;
        send_frame(1, 0, -1, N);
        send_frame(1, 0, -1, N);
        src_idle();
        pulse_flush();
        drain("impulse");
        chk("impulse_count", 32'(delivered), 32'd32);

        send_frame(0, 0, -1, N);
        src_idle();
        drain("autoflush");

        send_frame(0, 1, -1, N);
        send_frame(0, 1, -1, N);
        src_idle();
        pulse_flush();
        drain("gapped");

        saw_stall = 0;
        for (int f = 0; f < 4; f++) send_frame(0, 0, -1, N);
        src_idle();
        chk("ready_drop_full", 32'(saw_stall), 32'd1);
        pulse_flush();
        drain("backpressure");

        chk("err_clear", 32'(err_misalign), 32'd0);
        send_frame(0, 0, 5, N);
        src_idle();
        chk("err_set", 32'(err_misalign), 32'd1);
        pulse_flush();
        drain("misalign");
        chk("err_sticky", 32'(err_misalign), 32'd1);

        send_frame(0, 0, -1, 7);
        @(negedge clk);
        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_last   = 1'b0;
        sb.delete();
        model_idx = '0;
        src_cnt  = 0;
        last_acc = 0;
        @(negedge clk);
        reset_chk("rst_mid");
        rst_n = 1'b1;
        delivered = 0;
        send_frame(0, 0, -1, N);
        src_idle();
        pulse_flush();
        drain("post_reset");
        chk("post_reset_count", 32'(delivered), 32'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
